// File: rtl/temp_sense_sar.sv
// temp_sense_sar: divided-clock 8-bit successive-approximation controller for an external DAC/comparator temperature sensor
module temp_sense_sar #(
    parameter int CLK_DIV = 80
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       temp_en,
    input  logic       temp_clear,
    input  logic       comp_in,
    output logic [7:0] dac_code,
    output logic       temp_valid,
    output logic [7:0] temp_val
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    logic [1:0] sync_q, sync_d;
    logic [9:0] div_cnt_q, div_cnt_d;
    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] dac_q, dac_d, val_q, val_d, trial;
    logic       valid_q, valid_d, tick, comp_s;

    assign comp_s     = sync_q[1];
    assign dac_code   = dac_q;
    assign temp_valid = valid_q;
    assign temp_val   = val_q;

    // Tick divider, held at zero while disabled, plus comparator synchronizer shift
    always_comb begin
        tick      = temp_en && (div_cnt_q == DIV_LAST);
        div_cnt_d = (!temp_en || tick) ? 10'd0 : div_cnt_q + 10'd1;
        sync_d    = {sync_q[0], comp_in};
    end

    // SAR sequencing: one bit decided per tick; clear and disable win over everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dac_d   = dac_q;
        val_d   = val_q;
        valid_d = valid_q;
        trial   = dac_q;
        if (!comp_s) trial[idx_q] = 1'b0;
        if (idx_q != 3'd0) trial[idx_q - 3'd1] = 1'b1;
        if (!temp_en || (tick && temp_clear)) begin
            state_d = IDLE;
            idx_d   = 3'd7;
            dac_d   = 8'h00;
            valid_d = 1'b0;
        end else if (tick) begin
            if (state_q == IDLE) begin
                state_d = CONVERT;
                idx_d   = 3'd7;
                dac_d   = 8'h80;
            end else if (state_q == CONVERT) begin
                if (idx_q == 3'd0) begin
                    val_d   = trial;
                    valid_d = 1'b1;
                    dac_d   = 8'h00;
                    state_d = DONE;
                end else begin
                    dac_d = trial;
                    idx_d = idx_q - 3'd1;
                end
            end else if (state_q != DONE) begin
                state_d = IDLE;
                dac_d   = 8'h00;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            sync_q    <= 2'b00;
            div_cnt_q <= 10'd0;
            state_q   <= IDLE;
            idx_q     <= 3'd7;
            dac_q     <= 8'h00;
            val_q     <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            dac_q     <= dac_d;
            val_q     <= val_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: doc/temp_sense_sar.md
TEMP_SENSE_SAR -- requirements
Module: temp_sense_sar

Interface
REQ-001 Parameter CLK_DIV, default 80, meaning: clk_50mhz cycles per internal ADC tick; legal range 4..1023.
REQ-002 clk_50mhz  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 temp_en  input  1  sensor enable from the poller; low disables the divider and conversion.
REQ-005 temp_clear  input  1  clear request from the poller; acted on only at an ADC tick.
REQ-006 comp_in  input  1  asynchronous analog comparator output; 1 when sensed voltage >= dac_code.
REQ-007 dac_code  output  8  registered trial code driven to the external DAC.
REQ-008 temp_valid  output  1  registered; high while temp_val holds a completed, uncleared reading.
REQ-009 temp_val  output  8  registered result of the last completed conversion.

Function
REQ-010 comp_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value comp_s.
REQ-011 Divider div_cnt SHALL count 0..CLK_DIV-1 and wrap while temp_en=1; tick SHALL be high in the cycle where div_cnt==CLK_DIV-1.
REQ-012 While temp_en=0, div_cnt SHALL be held at 0, tick SHALL stay low, and the state machine SHALL be forced to IDLE with temp_valid=0 and dac_code=0.
REQ-013 First tick after temp_en rises SHALL occur exactly CLK_DIV cycles after the first cycle with temp_en=1.
REQ-014 States: IDLE, CONVERT, DONE; all transitions SHALL occur only on tick cycles, except REQ-012 and reset.
REQ-015 On any tick with temp_clear=1, from any state: next state IDLE, temp_valid<=0, dac_code<=0, temp_val unchanged (clear takes priority over every other tick action).
REQ-016 IDLE, tick, temp_clear=0: go to CONVERT, bit index<=7, dac_code<=0x80.
REQ-017 CONVERT, tick, temp_clear=0: if comp_s=0, clear dac_code[index]; if index>0, set dac_code[index-1] and decrement index.
REQ-018 CONVERT, tick, index==0: after the bit-0 decision, temp_val<=final code, temp_valid<=1, dac_code<=0, go to DONE, all in the same edge.
REQ-019 Latency: temp_valid SHALL rise on the 9th tick counted from (and including) the start tick of REQ-016.
REQ-020 DONE SHALL hold temp_valid=1 and temp_val stable indefinitely until a clearing tick, temp_en=0, or reset; no new conversion starts from DONE.
REQ-021 A temp_clear pulse that is low at every tick SHALL have no effect.
REQ-022 Arithmetic is unsigned 8-bit; results 0x00 and 0xFF SHALL be reachable with no wrap or saturation artefacts.
REQ-023 dac_code SHALL be 0 in IDLE and DONE.

Reset
REQ-024 In any cycle with reset_n=0, the next state SHALL be: IDLE, div_cnt=0, index=7, dac_code=0, temp_valid=0, temp_val=0, synchronizer flops=0.
REQ-025 Reset SHALL override temp_en, temp_clear and tick, including mid-conversion; no partial result SHALL reach temp_val.
REQ-026 First tick after reset release with temp_en=1 SHALL follow REQ-013, counted from the first cycle with reset_n=1.

Verification (CLK_DIV=4; analog model: comp_in = (dac_code <= VIN))
REQ-027 reset_n low 2 cycles mid-conversion -> dac_code=0, temp_valid=0, temp_val=0 on the next cycle.
REQ-028 en=1, clear=1 for 64 cycles, then clear=0, VIN=0x2B -> dac_code 80,40,20,30,28,2C,2A,2B on successive ticks; temp_valid=1, temp_val=0x2B on the 9th tick.
REQ-029 VIN=0xFF then VIN=0x00, each in a separate poll cycle -> temp_val=0xFF, then 0x00; temp_valid=1 each time.
REQ-030 clear=1 across the 4th conversion tick after a prior result 0x2B -> IDLE, temp_valid=0, temp_val stays 0x2B; clear=0 restarts conversion with dac_code=0x80.
REQ-031 temp_en dropped mid-conversion -> next cycle div_cnt=0, dac_code=0, temp_valid=0; re-enable -> first tick 4 cycles later.
REQ-032 clear held low for 20 ticks after valid -> temp_valid stays 1, temp_val stable, dac_code stays 0; a 2-cycle clear pulse between ticks -> no change.
